// File: rtl/axi4_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_sram_slave: AXI4-Lite word SRAM with byte strobes, latency, range check.
// Optional AXI4_LITE_SRAM_LFSR_DELAY_EN adds 0-3 LFSR cycles per access. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi4_lite_sram_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    RD_LATENCY = 1,
  parameter int                    WR_LATENCY = 1
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    pAXI4_ar_valid,
  output logic                    pAXI4_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   pAXI4_ar_bits_addr,
  output logic                    pAXI4_r_valid,
  input  logic                    pAXI4_r_ready,
  output logic [DATA_WIDTH-1:0]   pAXI4_r_bits_data,
  output logic [1:0]              pAXI4_r_bits_resp,
  input  logic                    pAXI4_aw_valid,
  output logic                    pAXI4_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   pAXI4_aw_bits_addr,
  input  logic                    pAXI4_w_valid,
  output logic                    pAXI4_w_ready,
  input  logic [DATA_WIDTH-1:0]   pAXI4_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0] pAXI4_w_bits_strb,
  output logic                    pAXI4_b_valid,
  input  logic                    pAXI4_b_ready,
  output logic [1:0]              pAXI4_b_bits_resp
);

  localparam int                  STRB_WIDTH = DATA_WIDTH / 8;
  localparam int                  SHIFT      = $clog2(STRB_WIDTH);
  localparam int                  IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                  CNT_W      = $clog2(RD_LATENCY + WR_LATENCY + 5) + 1;
  localparam logic [ADDR_WIDTH:0] LIMIT      = (ADDR_WIDTH + 1)'(DEPTH * STRB_WIDTH);
  localparam logic [1:0]          OKAY       = 2'b00;
  localparam logic [1:0]          SLVERR     = 2'b10;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  rd_state_t             rd_state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_W-1:0]      rd_cnt;
  wr_state_t             wr_state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [CNT_W-1:0]      wr_cnt;
  logic                  aw_held;
  logic                  w_held;
  logic [1:0]            extra;

`ifdef AXI4_LITE_SRAM_LFSR_DELAY_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) lfsr <= 8'hA5;
    else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif

  logic [CNT_W-1:0] rd_load;
  logic [CNT_W-1:0] wr_load;
  assign rd_load = CNT_W'(RD_LATENCY) + CNT_W'(extra);
  assign wr_load = CNT_W'(WR_LATENCY) + CNT_W'(extra);

  logic [ADDR_WIDTH-1:0] rd_off;
  logic [ADDR_WIDTH-1:0] wr_off;
  logic                  rd_ok;
  logic                  wr_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  assign rd_off = rd_addr - BASE_ADDR;
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_ok  = (rd_addr >= BASE_ADDR) && ({1'b0, rd_off} < LIMIT);
  assign wr_ok  = (wr_addr >= BASE_ADDR) && ({1'b0, wr_off} < LIMIT);
  assign rd_idx = rd_off[IDX_W+SHIFT-1:SHIFT];
  assign wr_idx = wr_off[IDX_W+SHIFT-1:SHIFT];

  logic aw_got;
  logic w_got;
  logic wr_commit;
  assign aw_got    = aw_held | (pAXI4_aw_ready & pAXI4_aw_valid);
  assign w_got     = w_held  | (pAXI4_w_ready  & pAXI4_w_valid);
  assign wr_commit = (wr_state == WR_WAIT) && (wr_cnt == '0) && wr_ok;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      rd_state          <= RD_IDLE;
      pAXI4_ar_ready    <= 1'b0;
      rd_addr           <= '0;
      rd_cnt            <= '0;
      pAXI4_r_valid     <= 1'b0;
      pAXI4_r_bits_data <= '0;
      pAXI4_r_bits_resp <= OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (pAXI4_ar_ready && pAXI4_ar_valid) begin
            rd_addr        <= pAXI4_ar_bits_addr;
            rd_cnt         <= rd_load;
            pAXI4_ar_ready <= 1'b0;
            rd_state       <= RD_WAIT;
          end else begin
            pAXI4_ar_ready <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (rd_cnt == '0) begin
            // Non-blocking read of mem returns pre-commit data on a same-edge write
            pAXI4_r_bits_data <= rd_ok ? mem[rd_idx] : '0;
            pAXI4_r_bits_resp <= rd_ok ? OKAY : SLVERR;
            pAXI4_r_valid     <= 1'b1;
            rd_state          <= RD_RESP;
          end else begin
            rd_cnt <= rd_cnt - CNT_W'(1);
          end
        end
        RD_RESP: begin
          if (pAXI4_r_ready) begin
            pAXI4_r_valid <= 1'b0;
            rd_state      <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      wr_state          <= WR_IDLE;
      pAXI4_aw_ready    <= 1'b0;
      pAXI4_w_ready     <= 1'b0;
      aw_held           <= 1'b0;
      w_held            <= 1'b0;
      wr_addr           <= '0;
      wr_data           <= '0;
      wr_strb           <= '0;
      wr_cnt            <= '0;
      pAXI4_b_valid     <= 1'b0;
      pAXI4_b_bits_resp <= OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (pAXI4_aw_ready && pAXI4_aw_valid) begin
            wr_addr        <= pAXI4_aw_bits_addr;
            aw_held        <= 1'b1;
            pAXI4_aw_ready <= 1'b0;
          end else if (!aw_held) begin
            pAXI4_aw_ready <= 1'b1;
          end
          if (pAXI4_w_ready && pAXI4_w_valid) begin
            wr_data       <= pAXI4_w_bits_data;
            wr_strb       <= pAXI4_w_bits_strb;
            w_held        <= 1'b1;
            pAXI4_w_ready <= 1'b0;
          end else if (!w_held) begin
            pAXI4_w_ready <= 1'b1;
          end
          if (aw_got && w_got) begin
            wr_cnt   <= wr_load;
            wr_state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (wr_cnt == '0) begin
            pAXI4_b_bits_resp <= wr_ok ? OKAY : SLVERR;
            pAXI4_b_valid     <= 1'b1;
            wr_state          <= WR_RESP;
          end else begin
            wr_cnt <= wr_cnt - CNT_W'(1);
          end
        end
        WR_RESP: begin
          if (pAXI4_b_ready) begin
            pAXI4_b_valid <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            wr_state      <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Storage is deliberately unreset; an aborted write never reaches here since wr_state resets
  always_ff @(posedge iClock) begin
    if (wr_commit) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_sram_slave: directed bench for axi4_lite_sram_slave. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi4_lite_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [31:0] ar_addr = '0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [31:0] aw_addr = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [1:0]  b_resp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  axi4_lite_sram_slave dut (
    .iClock             (clk),
    .iReset             (rst_n),
    .pAXI4_ar_valid     (ar_valid),
    .pAXI4_ar_ready     (ar_ready),
    .pAXI4_ar_bits_addr (ar_addr),
    .pAXI4_r_valid      (r_valid),
    .pAXI4_r_ready      (r_ready),
    .pAXI4_r_bits_data  (r_data),
    .pAXI4_r_bits_resp  (r_resp),
    .pAXI4_aw_valid     (aw_valid),
    .pAXI4_aw_ready     (aw_ready),
    .pAXI4_aw_bits_addr (aw_addr),
    .pAXI4_w_valid      (w_valid),
    .pAXI4_w_ready      (w_ready),
    .pAXI4_w_bits_data  (w_data),
    .pAXI4_w_bits_strb  (w_strb),
    .pAXI4_b_valid      (b_valid),
    .pAXI4_b_ready      (b_ready),
    .pAXI4_b_bits_resp  (b_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int   n;
    int   cap;
    logic hs;
    ar_valid = 1'b1;
    ar_addr  = addr;
    r_ready  = 1'b1;
    n = 0;
    while (ar_valid && n < 40) begin
      hs = ar_ready;
      step();
      n++;
      if (hs) ar_valid = 1'b0;
    end
    chk("rd_ar_timeout", n < 40, 1);
    ar_valid = 1'b0;
    cap = cyc;
    n = 0;
    while (!r_valid && n < 40) begin
      step();
      n++;
    end
    chk("rd_r_timeout", r_valid, 1);
    lat  = cyc - cap;
    data = r_data;
    resp = r_resp;
    step();
    r_ready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp, output int lat);
    int   n;
    int   cap;
    logic hsa;
    logic hsw;
    aw_valid = 1'b1;
    aw_addr  = addr;
    w_valid  = 1'b1;
    w_data   = data;
    w_strb   = strb;
    b_ready  = 1'b1;
    n = 0;
    while ((aw_valid || w_valid) && n < 40) begin
      hsa = aw_ready;
      hsw = w_ready;
      step();
      n++;
      if (hsa) aw_valid = 1'b0;
      if (hsw) w_valid = 1'b0;
    end
    chk("wr_cap_timeout", n < 40, 1);
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    cap = cyc;
    n = 0;
    while (!b_valid && n < 40) begin
      step();
      n++;
    end
    chk("wr_b_timeout", b_valid, 1);
    lat  = cyc - cap;
    resp = b_resp;
    step();
    b_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  rs;
    int          lt;
    int          n;
    int          cap;
    logic        hs;

    // Power-on reset values
    #2;
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_w_ready",  w_ready, 0);
    chk("rst_r_valid",  r_valid, 0);
    chk("rst_b_valid",  b_valid, 0);
    chk("rst_r_data",   r_data, 0);
    chk("rst_r_resp",   r_resp, 0);
    chk("rst_b_resp",   b_resp, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Preload through the bus, then reset again: memory must survive
    do_write(32'h8000_0000, 32'hA5A5_0001, 4'hF, rs, lt);
    chk("pre0_resp", rs, 0);
    do_write(32'h8000_0004, 32'h1234_5678, 4'hF, rs, lt);
    do_write(32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, rs, lt);
    do_read(32'h8000_0000, d, rs, lt);
    chk("pre_rd_data", d, 32'hA5A5_0001);

    step();
    rst_n = 1'b0;
    #1;
    chk("rst2_r_data",   r_data, 0);
    chk("rst2_ar_ready", ar_ready, 0);
    chk("rst2_aw_ready", aw_ready, 0);
    chk("rst2_w_ready",  w_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    chk("rel_ar_ready_pre", ar_ready, 0);
    step();
    chk("rel_ar_ready", ar_ready, 1);
    chk("rel_aw_ready", aw_ready, 1);
    chk("rel_w_ready",  w_ready, 1);

    // Basic read latency and preserved contents
    do_read(32'h8000_0000, d, rs, lt);
    chk("t1_lat",  lt, 2);
    chk("t1_data", d, 32'hA5A5_0001);
    chk("t1_resp", rs, 0);

    // Strobed write
    do_write(32'h8000_0004, 32'hDEAD_BEEF, 4'b0011, rs, lt);
    chk("t2_lat",  lt, 2);
    chk("t2_resp", rs, 0);
    do_read(32'h8000_0004, d, rs, lt);
    chk("t2_data", d, 32'h1234_BEEF);

    // W ahead of AW by three cycles
    w_valid = 1'b1;
    w_data  = 32'h0BAD_F00D;
    w_strb  = 4'hF;
    b_ready = 1'b1;
    step();
    w_data = 32'hFFFF_FFFF;
    chk("t3_w_ready_low", w_ready, 0);
    step();
    step();
    chk("t3_w_ready_wait", w_ready, 0);
    chk("t3_aw_ready",     aw_ready, 1);
    chk("t3_b_idle",       b_valid, 0);
    w_valid  = 1'b0;
    aw_valid = 1'b1;
    aw_addr  = 32'h8000_0008;
    step();
    aw_valid = 1'b0;
    cap = cyc;
    n = 0;
    while (!b_valid && n < 40) begin
      step();
      n++;
    end
    chk("t3_b_seen", b_valid, 1);
    chk("t3_lat",    cyc - cap, 2);
    chk("t3_resp",   b_resp, 0);
    step();
    b_ready = 1'b0;
    do_read(32'h8000_0008, d, rs, lt);
    chk("t3_data", d, 32'h0BAD_F00D);

    // Out-of-range accesses
    do_read(32'h7FFF_FFFC, d, rs, lt);
    chk("t4_rd_resp", rs, 2'b10);
    chk("t4_rd_data", d, 0);
    do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, rs, lt);
    chk("t4_wr_resp", rs, 2'b10);
    do_read(32'h8000_0FFC, d, rs, lt);
    chk("t4_last_data", d, 32'hCAFE_F00D);
    chk("t4_last_resp", rs, 0);
    do_read(32'h8000_0000, d, rs, lt);
    chk("t4_word0", d, 32'hA5A5_0001);

    // r_ready held low: response holds
    ar_valid = 1'b1;
    ar_addr  = 32'h8000_0004;
    r_ready  = 1'b0;
    n = 0;
    while (ar_valid && n < 40) begin
      hs = ar_ready;
      step();
      n++;
      if (hs) ar_valid = 1'b0;
    end
    ar_valid = 1'b0;
    n = 0;
    while (!r_valid && n < 40) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t5_r_valid",  r_valid, 1);
      chk("t5_r_data",   r_data, 32'h1234_BEEF);
      chk("t5_r_resp",   r_resp, 0);
      chk("t5_ar_ready", ar_ready, 0);
      step();
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    chk("t5_r_drop", r_valid, 0);
    step();
    chk("t5_ar_rearm", ar_ready, 1);

    // Read and write of the same word on the same edge: read sees old data
    chk("col_aw_ready", aw_ready, 1);
    ar_valid = 1'b1;
    ar_addr  = 32'h8000_0008;
    aw_valid = 1'b1;
    aw_addr  = 32'h8000_0008;
    w_valid  = 1'b1;
    w_data   = 32'h1111_2222;
    w_strb   = 4'hF;
    r_ready  = 1'b1;
    b_ready  = 1'b1;
    step();
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    n = 0;
    while (!r_valid && n < 40) begin
      step();
      n++;
    end
    chk("col_r_data",  r_data, 32'h0BAD_F00D);
    chk("col_b_valid", b_valid, 1);
    step();
    r_ready = 1'b0;
    b_ready = 1'b0;
    do_read(32'h8000_0008, d, rs, lt);
    chk("col_new_data", d, 32'h1111_2222);

    // Reset during WR_WAIT with a read parked in RD_RESP
    ar_valid = 1'b1;
    ar_addr  = 32'h8000_0000;
    r_ready  = 1'b0;
    n = 0;
    while (ar_valid && n < 40) begin
      hs = ar_ready;
      step();
      n++;
      if (hs) ar_valid = 1'b0;
    end
    ar_valid = 1'b0;
    n = 0;
    while (!r_valid && n < 40) begin
      step();
      n++;
    end
    chk("t6_r_parked", r_valid, 1);
    aw_valid = 1'b1;
    aw_addr  = 32'h8000_0004;
    w_valid  = 1'b1;
    w_data   = 32'hFFFF_FFFF;
    w_strb   = 4'hF;
    b_ready  = 1'b1;
    step();
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    chk("t6_in_wait", b_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_r_async_drop", r_valid, 0);
    chk("t6_b_low", b_valid, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t6_b_after", b_valid, 0);
    b_ready = 1'b0;
    do_read(32'h8000_0004, d, rs, lt);
    chk("t6_mem_kept", d, 32'h1234_BEEF);
    do_write(32'h8000_0004, 32'h5566_7788, 4'b1100, rs, lt);
    chk("t6_fresh_lat",  lt, 2);
    chk("t6_fresh_resp", rs, 0);
    do_read(32'h8000_0004, d, rs, lt);
    chk("t6_fresh_data", d, 32'h5566_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi4_lite_sram_slave.md
# axi4_lite_sram_slave

AXI4-Lite slave memory that sits directly downstream of the core's AXI4-Lite master and answers its read and write transactions. It gives the CPU a word-addressed SRAM with byte strobes, programmable response latency and address-range checking. It exercises the master's handshake logic under non-zero and, optionally, randomised latency. Read and write channels run independent state machines, so one read and one write may be in flight at the same time.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width (32 or 64).
- `DEPTH`, 1024, number of `DATA_WIDTH` words.
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0.
- `RD_LATENCY`, 1, cycles from AR handshake to `r_valid` rise.
  - 0 means `r_valid` rises on the next cycle.
- `WR_LATENCY`, 1, cycles from write capture to `b_valid` rise.
- `iClock` in 1: the single clock.
- `iReset` in 1: asynchronous, active-low reset.
- `pAXI4_ar_valid` in 1, `pAXI4_ar_ready` out 1, `pAXI4_ar_bits_addr` in ADDR_WIDTH: read address channel.
- `pAXI4_r_valid` out 1, `pAXI4_r_ready` in 1, `pAXI4_r_bits_data` out DATA_WIDTH, `pAXI4_r_bits_resp` out 2: read data channel.
- `pAXI4_aw_valid` in 1, `pAXI4_aw_ready` out 1, `pAXI4_aw_bits_addr` in ADDR_WIDTH: write address channel.
- `pAXI4_w_valid` in 1, `pAXI4_w_ready` out 1, `pAXI4_w_bits_data` in DATA_WIDTH, `pAXI4_w_bits_strb` in DATA_WIDTH/8: write data channel.
- `pAXI4_b_valid` out 1, `pAXI4_b_ready` in 1, `pAXI4_b_bits_resp` out 2: write response channel.

## Operation
- Word index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8). Low address bits are ignored.
- An address is in range when BASE_ADDR ≤ addr < BASE_ADDR + DEPTH·DATA_WIDTH/8.
- Responses: OKAY = 2'b00, SLVERR = 2'b10.
- Read FSM, states RD_IDLE → RD_WAIT → RD_RESP:
  - RD_IDLE: `ar_ready`=1. On AR handshake, latch the address, load the counter with the latency, and go to RD_WAIT.
  - RD_WAIT: counter decrements each cycle. On reaching 0, sample memory into the data register and go to RD_RESP. With latency 0, go straight to RD_RESP on the edge after the handshake.
  - RD_RESP: `r_valid`=1; data and resp are held stable until the R handshake, then return to RD_IDLE.
  - Out-of-range read: data 0, resp SLVERR.
- Write FSM, states WR_IDLE → WR_WAIT → WR_RESP:
  - WR_IDLE: `aw_ready`=1 until AW is captured; `w_ready`=1 until W is captured. AW and W are captured independently, in either order or in the same cycle.
  - When both are held, go to WR_WAIT with the counter loaded.
  - On counter 0, commit the write to memory on the edge entering WR_RESP.
  - Byte lane i is written only when strb[i]=1.
  - Out-of-range write: no memory update, resp SLVERR.
  - WR_RESP: `b_valid`=1 until the B handshake, then return to WR_IDLE.
- Same-edge collision: if a read samples the same word on the edge where a write commits, the read returns the old data.
- The memory array is not reset and holds its contents across reset.

## Timing
- Reset values, applied immediately on `iReset`=0:
  - `ar_ready`=0, `aw_ready`=0, `w_ready`=0.
  - `r_valid`=0, `b_valid`=0.
  - `r_bits_data`=0, `r_bits_resp`=0, `b_bits_resp`=0.
  - Both FSMs go to IDLE; counters and captured AW/W are cleared.
- `ar_ready`, `aw_ready` and `w_ready` assert on the first clock edge after reset deasserts.
- Reset asserted mid-transaction aborts it:
  - A pending write is not committed.
  - `r_valid` and `b_valid` drop asynchronously.
- Read latency with `r_ready` held high:
  - AR handshake at edge N.
  - `r_valid` high from edge N+1+RD_LATENCY.
  - R handshake at that edge; RD_IDLE after it.
  - `ar_ready` high again one cycle after the R handshake.
- Write latency: last of AW/W captured at edge N; `b_valid` high from edge N+1+WR_LATENCY.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- `AXI4_LITE_SRAM_LFSR_DELAY_EN` defined:
  - An 8-bit LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - At each AR handshake and each write capture, the loaded latency = configured latency + LFSR[1:0] (adds 0–3 cycles).
- Undefined: no LFSR; latency is exactly RD_LATENCY / WR_LATENCY.

## Test plan
- Reset release, macro off, RD_LATENCY=1: `ar_ready` rises one edge later; AR 0x8000_0000 with `r_ready`=1 → `r_valid` two edges after the handshake, data as preloaded, resp 00.
- Write 0x8000_0004 data 0xDEADBEEF strb 4'b0011 over old 0x12345678 → `b_valid` at N+2, resp 00; readback gives 0x1234BEEF.
- W presented 3 cycles before AW → W captured and `w_ready` low while waiting; after the AW handshake, `b_valid` at N+2 and data written.
- Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH=1024, 32-bit) → resp 10 on both; read data 0; memory unchanged.
- `r_ready` held low 5 cycles → `r_valid`, data and resp held stable; `ar_ready` stays 0 until the handshake.
- `iReset` pulsed low while in WR_WAIT → `b_valid` stays 0 and memory is unchanged; after release a fresh write completes normally.
